rpn_ctrl: RTL and testbench

RPN_CTRL -- requirements
Module: rpn_ctrl

---
 rtl/rpn_ctrl_if.sv | 31 +++
 rtl/rpn_ctrl.sv | 142 ++++++++++++++
 tb/tb_rpn_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_ctrl_if.sv
// Command, stack and result signals between the RPN controller and its environment.
// The controller takes the slave side; the command source and attached stack take the master side.
interface rpn_ctrl_if #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_data;
  logic             o_stk_push;
  logic             o_stk_pop;
  logic [WIDTH-1:0] o_stk_data;
  logic [WIDTH-1:0] i_stk_data;
  logic [WIDTH-1:0] o_result;
  logic             o_result_valid;
  logic [DW-1:0]    o_depth;
  logic             o_err;

  modport slave (
    input  i_valid, i_op, i_data, i_stk_data,
    output o_ready, o_stk_push, o_stk_pop, o_stk_data, o_result, o_result_valid, o_depth, o_err
  );

  modport master (
    output i_valid, i_op, i_data, i_stk_data,
    input  o_ready, o_stk_push, o_stk_pop, o_stk_data, o_result, o_result_valid, o_depth, o_err
  );
endinterface

// File: rtl/rpn_ctrl.sv
// RPN command controller: sequences push/pop strobes on an external stack, evaluates binary
// ops, DUP and PEEK, and tracks stack depth with sticky underflow/overflow detection.
module rpn_ctrl #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  rpn_ctrl_if.slave    bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] Full = DW'(DEPTH);

  localparam logic [2:0] OpPush = 3'd0, OpAdd = 3'd1, OpSub = 3'd2, OpAnd = 3'd3,
                         OpOr   = 3'd4, OpXor = 3'd5, OpDup = 3'd6, OpPeek = 3'd7;

  localparam logic [3:0] StIdle = 4'd0, StPush = 4'd1, StPopB = 4'd2, StPopA = 4'd3,
                         StWrite = 4'd4, StDup1 = 4'd5, StDup2 = 4'd6, StPeek1 = 4'd7,
                         StErr = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q, b_q, result_q, alu;
  logic [DW-1:0]    depth_q;
  logic             err_q, result_valid_q;
  logic             accept, underflow, overflow;

  assign accept = bus.i_valid && (state_q == StIdle) && !i_rst;

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    case (bus.i_op)
      OpPush: overflow = (depth_q == Full);
      OpDup: begin
        underflow = (depth_q == '0);
        overflow  = (depth_q == Full);
      end
      OpPeek:  underflow = (depth_q == '0);
      default: underflow = (depth_q < DW'(2));
    endcase
  end

  // a is the deeper operand, arriving from the second pop.
  always_comb begin
    case (op_q)
      OpAdd:   alu = bus.i_stk_data + b_q;
      OpSub:   alu = bus.i_stk_data - b_q;
      OpAnd:   alu = bus.i_stk_data & b_q;
      OpOr:    alu = bus.i_stk_data | b_q;
      OpXor:   alu = bus.i_stk_data ^ b_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (underflow || overflow) begin
            state_d = StErr;
          end else begin
            case (bus.i_op)
              OpPush:  state_d = StPush;
              OpDup:   state_d = StDup1;
              default: state_d = StPopB;
            endcase
          end
        end
      end
      StPopB:  state_d = (op_q == OpPeek) ? StPeek1 : StPopA;
      StPopA:  state_d = StWrite;
      StDup1:  state_d = StDup2;
      StDup2:  state_d = StPush;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      op_q           <= '0;
      data_q         <= '0;
      b_q            <= '0;
      result_q       <= '0;
      depth_q        <= '0;
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= 1'b0;
      if (accept) begin
        op_q   <= bus.i_op;
        data_q <= bus.i_data;
        if (underflow || overflow) err_q <= 1'b1;
      end
      case (state_q)
        StPush:  depth_q <= depth_q + 1'b1;
        StPopA:  b_q <= bus.i_stk_data;
        StWrite: begin
          depth_q        <= depth_q - 1'b1;
          result_q       <= alu;
          result_valid_q <= 1'b1;
        end
        // DUP re-uses StPush to write the registered copy as its final strobe.
        StDup2:  data_q <= bus.i_stk_data;
        StPeek1: begin
          result_q       <= bus.i_stk_data;
          result_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic push_st, pop_st;
  assign push_st = (state_q == StPush) || (state_q == StWrite) || (state_q == StDup2) ||
                   (state_q == StPeek1);
  assign pop_st  = (state_q == StPopB) || (state_q == StPopA) || (state_q == StDup1);

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    bus.o_stk_data = '0;
    if (!i_rst) begin
      case (state_q)
        StPush:          bus.o_stk_data = data_q;
        StWrite:         bus.o_stk_data = alu;
        StDup2, StPeek1: bus.o_stk_data = bus.i_stk_data;
        default:         bus.o_stk_data = '0;
      endcase
    end
  end

  assign bus.o_ready        = !i_rst && (state_q == StIdle);
  assign bus.o_stk_push     = !i_rst && push_st;
  assign bus.o_stk_pop      = !i_rst && pop_st;
  assign bus.o_result       = i_rst ? '0 : result_q;
  assign bus.o_result_valid = !i_rst && result_valid_q;
  assign bus.o_depth        = i_rst ? '0 : depth_q;
  assign bus.o_err          = !i_rst && err_q;
endmodule

// File: tb/tb_rpn_ctrl.sv
// Bench for rpn_ctrl: behavioural stack, reference model and result scoreboard.
module tb_rpn_ctrl;
  localparam int W  = 18;
  localparam int D  = 16;
  localparam int DW = $clog2(D + 1);

  localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, DUP = 3'd6, PEEK = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();
  rpn_ctrl #(.WIDTH(W), .DEPTH(D)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached stack: read data is valid the cycle after a pop.
  logic [W-1:0] mem [D];
  int           sp;
  logic [W-1:0] rd;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      rd <= '0;
    end else if (bus.o_stk_push) begin
      if (sp < D) mem[sp] <= bus.o_stk_data;
      sp <= sp + 1;
    end else if (bus.o_stk_pop) begin
      if (sp > 0) rd <= mem[sp-1];
      sp <= sp - 1;
    end
  end
  assign bus.i_stk_data = rd;

  logic [W-1:0] mstk[$];
  logic [W-1:0] sb[$];
  bit           merr;
  int           push_cnt = 0;
  int           pop_cnt = 0;

  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (bus.o_stk_push) push_cnt++;
    if (bus.o_stk_pop) pop_cnt++;
    if (bus.o_stk_push && bus.o_stk_pop) begin
      checks++;
      errors++;
      $display("FAIL strobe_excl: push=1 pop=1 at cycle %0d, required not both", cyc);
    end
    if (bus.o_result_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %h with no result pending", bus.o_result);
      end else begin
        exp = sb.pop_front();
        if (bus.o_result !== exp) begin
          errors++;
          $display("FAIL result: got %h required %h", bus.o_result, exp);
        end
      end
    end
  end

  task automatic model(input logic [2:0] op, input logic [W-1:0] d);
    logic [W-1:0] a, b, r;
    case (op)
      PUSH: if (mstk.size() == D) merr = 1; else mstk.push_back(d);
      DUP: begin
        if (mstk.size() == 0 || mstk.size() == D) merr = 1;
        else mstk.push_back(mstk[$]);
      end
      PEEK: if (mstk.size() == 0) merr = 1; else sb.push_back(mstk[$]);
      default: begin
        if (mstk.size() < 2) merr = 1;
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND_:    r = a & b;
            OR_:     r = a | b;
            default: r = a ^ b;
          endcase
          mstk.push_back(r);
          sb.push_back(r);
        end
      end
    endcase
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_op = '0;
    bus.i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mstk.delete();
    sb.delete();
    merr = 0;
  endtask

  // Returns just after the accepting edge; t is the acceptance cycle.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, output int t);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_data = d;
    for (int k = 0; k < 30 && !bus.o_ready; k++) @(negedge clk);
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: o_ready=0 after 30 cycles, required 1");
    end
    t = cyc;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = bus.o_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: o_ready=0 after 30 cycles, required 1");
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d);
    int t;
    model(op, d);
    issue(op, d, t);
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_op = '0;
    bus.i_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_ready, bus.o_stk_push, bus.o_stk_pop, bus.o_result_valid, bus.o_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: rdy/push/pop/rv/err=%b required 00000",
               {bus.o_ready, bus.o_stk_push, bus.o_stk_pop, bus.o_result_valid, bus.o_err});
    end
    checks++;
    if (bus.o_depth !== '0 || bus.o_result !== '0 || bus.o_stk_data !== '0) begin
      errors++;
      $display("FAIL reset_data: depth=%0d result=%h stk_data=%h required 0 0 0",
               bus.o_depth, bus.o_result, bus.o_stk_data);
    end
    rst = 1'b0;
    mstk.delete();
    sb.delete();
    merr = 0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: o_ready=%b after reset, required 1", bus.o_ready);
    end
  endtask

  task automatic test_add();
    int t;
    apply_reset();
    do_cmd(PUSH, 18'd5);
    do_cmd(PUSH, 18'd3);
    model(ADD, '0);
    issue(ADD, '0, t);
    @(negedge clk);
    checks++;
    if (bus.o_stk_pop !== 1'b1 || bus.o_stk_push !== 1'b0) begin
      errors++;
      $display("FAIL add_t1: pop=%b push=%b required 1 0", bus.o_stk_pop, bus.o_stk_push);
    end
    @(negedge clk);
    checks++;
    if (bus.o_stk_pop !== 1'b1) begin
      errors++;
      $display("FAIL add_t2: pop=%b required 1", bus.o_stk_pop);
    end
    @(negedge clk);
    checks++;
    if (bus.o_stk_push !== 1'b1 || bus.o_stk_data !== 18'd8) begin
      errors++;
      $display("FAIL add_t3: push=%b data=%h required 1 00008", bus.o_stk_push, bus.o_stk_data);
    end
    @(negedge clk);
    checks++;
    if (bus.o_result_valid !== 1'b1 || bus.o_result !== 18'd8 || cyc != t + 4) begin
      errors++;
      $display("FAIL add_t4: valid=%b result=%h at T+%0d required 1 00008 at T+4",
               bus.o_result_valid, bus.o_result, cyc - t);
    end
    wait_idle();
    checks++;
    if (bus.o_depth !== DW'(1)) begin
      errors++;
      $display("FAIL add_depth: depth=%0d required 1", bus.o_depth);
    end
  endtask

  task automatic test_sub_wrap();
    apply_reset();
    do_cmd(PUSH, 18'd2);
    do_cmd(PUSH, 18'd3);
    do_cmd(SUB, '0);
    checks++;
    if (bus.o_result !== 18'h3FFFF || bus.o_depth !== DW'(1)) begin
      errors++;
      $display("FAIL sub_wrap: result=%h depth=%0d required 3ffff 1", bus.o_result, bus.o_depth);
    end
  endtask

  task automatic test_dup_xor_peek();
    apply_reset();
    do_cmd(PUSH, 18'h2A);
    do_cmd(DUP, '0);
    checks++;
    if (bus.o_depth !== DW'(2)) begin
      errors++;
      $display("FAIL dup_depth: depth=%0d required 2", bus.o_depth);
    end
    do_cmd(XOR_, '0);
    checks++;
    if (bus.o_result !== '0 || bus.o_depth !== DW'(1)) begin
      errors++;
      $display("FAIL dup_xor: result=%h depth=%0d required 0 1", bus.o_result, bus.o_depth);
    end
    do_cmd(PEEK, '0);
    checks++;
    if (bus.o_result !== '0 || bus.o_depth !== DW'(1)) begin
      errors++;
      $display("FAIL peek_zero: result=%h depth=%0d required 0 1", bus.o_result, bus.o_depth);
    end
  endtask

  task automatic test_underflow();
    int p, q;
    apply_reset();
    p = push_cnt;
    q = pop_cnt;
    do_cmd(ADD, '0);
    checks++;
    if (bus.o_err !== 1'b1 || push_cnt != p || pop_cnt != q || bus.o_depth !== '0) begin
      errors++;
      $display("FAIL underflow: err=%b pushes=%0d pops=%0d depth=%0d required 1 0 0 0",
               bus.o_err, push_cnt - p, pop_cnt - q, bus.o_depth);
    end
    do_cmd(PUSH, 18'd7);
    do_cmd(PEEK, '0);
    checks++;
    if (bus.o_result !== 18'd7 || bus.o_err !== 1'b1 || bus.o_depth !== DW'(1)) begin
      errors++;
      $display("FAIL err_sticky: result=%h err=%b depth=%0d required 00007 1 1",
               bus.o_result, bus.o_err, bus.o_depth);
    end
  endtask

  task automatic test_overflow();
    int p;
    apply_reset();
    for (int i = 0; i < D; i++) do_cmd(PUSH, W'(i + 1));
    checks++;
    if (bus.o_depth !== DW'(D) || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL fill: depth=%0d err=%b required %0d 0", bus.o_depth, bus.o_err, D);
    end
    p = push_cnt;
    do_cmd(PUSH, 18'd99);
    checks++;
    if (bus.o_depth !== DW'(D) || bus.o_err !== 1'b1 || push_cnt != p) begin
      errors++;
      $display("FAIL overflow: depth=%0d err=%b pushes=%0d required %0d 1 0",
               bus.o_depth, bus.o_err, push_cnt - p, D);
    end
    do_cmd(ADD, '0);
    checks++;
    if (bus.o_depth !== DW'(D - 1)) begin
      errors++;
      $display("FAIL overflow_add: depth=%0d required %0d", bus.o_depth, D - 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      op = (mstk.size() < 2) ? PUSH : 3'($urandom_range(0, 7));
      do_cmd(op, W'($urandom));
      checks++;
      if (bus.o_depth !== DW'(mstk.size()) || bus.o_err !== merr) begin
        errors++;
        $display("FAIL b2b_%0d: op=%0d depth=%0d err=%b required %0d %b",
                 i, op, bus.o_depth, bus.o_err, mstk.size(), merr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, p, q;
    apply_reset();
    do_cmd(PUSH, 18'd5);
    do_cmd(PUSH, 18'd3);
    issue(ADD, '0, t);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_stk_push !== 1'b0 || bus.o_stk_pop !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_strobe: push=%b pop=%b required 0 0", bus.o_stk_push, bus.o_stk_pop);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    p = push_cnt;
    q = pop_cnt;
    rst = 1'b0;
    mstk.delete();
    merr = 0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_depth !== '0) begin
      errors++;
      $display("FAIL rst_mid_ready: ready=%b depth=%0d required 1 0", bus.o_ready, bus.o_depth);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (push_cnt != p || pop_cnt != q) begin
      errors++;
      $display("FAIL rst_mid_quiet: pushes=%0d pops=%0d after reset required 0 0",
               push_cnt - p, pop_cnt - q);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op = '0;
    bus.i_data = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_dup_xor_peek();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results never produced, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
